// File: rtl/soc_axi_decerr_slave.sv
// AXI4 default-port responder: drains every unmapped transaction and answers it with DECERR,
// while logging the last offending address and a saturating transaction count.
module soc_axi_decerr_slave #(
    parameter int unsigned          IdWidth   = 5,
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [15:0]          err_cnt_o
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    wstate_e              w_state_q, w_state_d;
    rstate_e              r_state_q, r_state_d;
    logic [IdWidth-1:0]   b_id_q, r_id_q;
    logic [7:0]           r_len_q, r_cnt_q;
    logic [AddrWidth-1:0] err_addr_q;
    logic [15:0]          err_cnt_q;
    logic [16:0]          cnt_sum;
    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign w_hs  = w_valid_i  & w_ready_o;
    assign b_hs  = b_valid_o  & b_ready_i;
    assign ar_hs = ar_valid_i & ar_ready_o;
    assign r_hs  = r_valid_o  & r_ready_i;

    // Burst length on AW is informational only; W termination follows w_last_i.
    logic unused_aw_len;
    assign unused_aw_len = ^aw_len_i;

    // ---------------- write path ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) b_id_q <= aw_id_i;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_hs)             w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_i)  w_state_d = W_RESP;
            W_RESP:  if (b_hs)              w_state_d = W_IDLE;
            default:                        w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        unique case (w_state_q)
            W_IDLE:  aw_ready_o = 1'b1;
            W_DATA:  w_ready_o  = 1'b1;
            W_RESP:  b_valid_o  = 1'b1;
            default: aw_ready_o = 1'b0;
        endcase
    end

    assign b_id_o   = b_id_q;
    assign b_resp_o = 2'b11;

    // ---------------- read path ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id_q  <= ar_id_i;
                r_len_q <= ar_len_i;
                r_cnt_q <= '0;
            end else if (r_hs) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (ar_hs)             r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last_o)  r_state_d = R_IDLE;
            default:                        r_state_d = R_IDLE;
        endcase
    end

    // Payload is held in registers, so it cannot move while a beat is stalled.
    always_comb begin
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        unique case (r_state_q)
            R_IDLE:  ar_ready_o = 1'b1;
            R_DATA: begin
                r_valid_o = 1'b1;
                r_last_o  = (r_cnt_q == r_len_q);
            end
            default: ar_ready_o = 1'b0;
        endcase
    end

    assign r_id_o   = r_id_q;
    assign r_data_o = RespData;
    assign r_resp_o = 2'b11;

    // ---------------- error log ----------------
    // Simultaneous AW+AR counts twice; the read address wins the log slot.
    assign cnt_sum = {1'b0, err_cnt_q} + 17'(aw_hs) + 17'(ar_hs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (ar_hs)      err_addr_q <= ar_addr_i;
            else if (aw_hs) err_addr_q <= aw_addr_i;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_soc_axi_decerr_slave.sv
// Bench for soc_axi_decerr_slave: directed scenarios plus random traffic against a
// transaction-level scoreboard (expected B/R beats queued at each address handshake).
module tb_soc_axi_decerr_slave;
    localparam int IW = 5;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] RD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          aw_valid = 0, aw_ready;
    logic [IW-1:0] aw_id = '0;
    logic [AW-1:0] aw_addr = '0;
    logic [7:0]    aw_len = '0;
    logic          w_valid = 0, w_ready, w_last = 0;
    logic          b_valid, b_ready = 0;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;
    logic          ar_valid = 0, ar_ready;
    logic [IW-1:0] ar_id = '0;
    logic [AW-1:0] ar_addr = '0;
    logic [7:0]    ar_len = '0;
    logic          r_valid, r_ready = 0;
    logic [IW-1:0] r_id;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_last;
    logic [AW-1:0] err_addr;
    logic [15:0]   err_cnt;

    soc_axi_decerr_slave dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .err_addr_o(err_addr), .err_cnt_o(err_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } rbeat_t;
    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } bresp_t;

    rbeat_t      r_exp[$], r_obs[$];
    bresp_t      b_exp[$], b_obs[$];
    int unsigned m_cnt = 0;
    logic [63:0] m_addr = '0;

    // Advance one cycle: log handshakes seen at this negedge into the reference model.
    task automatic tick();
        logic awh, arh, rh, bh;
        rbeat_t e;
        bresp_t eb;
        awh = aw_valid && aw_ready;
        arh = ar_valid && ar_ready;
        rh  = r_valid && r_ready;
        bh  = b_valid && b_ready;
        if (awh) begin eb.id = aw_id; eb.resp = 2'b11; b_exp.push_back(eb); end
        if (arh)
            for (int i = 0; i <= int'(ar_len); i++) begin
                e.id = ar_id; e.data = RD; e.resp = 2'b11; e.last = (i == int'(ar_len));
                r_exp.push_back(e);
            end
        if (rh) begin e.id = r_id; e.data = r_data; e.resp = r_resp; e.last = r_last; r_obs.push_back(e); end
        if (bh) begin eb.id = b_id; eb.resp = b_resp; b_obs.push_back(eb); end
        m_cnt = m_cnt + 32'(awh) + 32'(arh);
        if (m_cnt > 32'hFFFF) m_cnt = 32'hFFFF;
        if (arh) m_addr = ar_addr;
        else if (awh) m_addr = aw_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        r_exp.delete(); r_obs.delete(); b_exp.delete(); b_obs.delete();
        m_cnt = 0; m_addr = '0;
    endtask

    task automatic test_reset();
        logic [95:0] v;
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        v = {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_id, r_id, err_addr, err_cnt};
        checks++;
        if (v !== {6'b110000, 90'd0}) begin
            errors++; $display("FAIL reset_outputs got %h want %h", v, {6'b110000, 90'd0});
        end
        rst_n = 1;
        clear_model();
        tick();
    endtask

    task automatic test_write();
        aw_valid = 1; aw_id = 5; aw_addr = 64'h7000_0000; aw_len = 3;
        checks++;
        if (aw_ready !== 1'b1 || w_ready !== 1'b0) begin
            errors++; $display("FAIL wr_idle aw_ready=%b w_ready=%b want 1 0", aw_ready, w_ready);
        end
        tick();
        aw_valid = 0;
        checks++;
        if (w_ready !== 1'b1 || aw_ready !== 1'b0) begin
            errors++; $display("FAIL wr_wready_n1 w_ready=%b aw_ready=%b want 1 0", w_ready, aw_ready);
        end
        checks++;
        if (err_cnt !== 16'd1 || err_addr !== 64'h7000_0000) begin
            errors++; $display("FAIL wr_log cnt=%0d addr=%h want 1 70000000", err_cnt, err_addr);
        end
        for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 1) == 1) begin w_valid = 0; tick(); end
            w_valid = 1; w_last = (b == 3);
            tick();
        end
        w_valid = 0; w_last = 0;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd5 || b_resp !== 2'b11) begin
            errors++; $display("FAIL wr_bresp valid=%b id=%0d resp=%b want 1 5 11", b_valid, b_id, b_resp);
        end
        b_ready = 1;
        tick();
        b_ready = 0;
        checks++;
        if (aw_ready !== 1'b1 || b_valid !== 1'b0) begin
            errors++; $display("FAIL wr_back_idle aw_ready=%b b_valid=%b want 1 0", aw_ready, b_valid);
        end
        checks++;
        if (b_obs.size() != 1 || b_obs[0] !== b_exp[0]) begin
            errors++; $display("FAIL wr_bcount got %0d want 1", b_obs.size());
        end
        b_obs.delete(); b_exp.delete();
    endtask

    task automatic test_read();
        ar_valid = 1; ar_id = 3; ar_len = 7; ar_addr = {$urandom, $urandom}; r_ready = 1;
        tick();
        ar_valid = 0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (r_valid !== 1'b1 || r_last !== (k == 7)) begin
                errors++; $display("FAIL rd_beat%0d valid=%b last=%b want 1 %b", k, r_valid, r_last, k == 7);
            end
            tick();
        end
        r_ready = 0;
        checks++;
        if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
            errors++; $display("FAIL rd_back_idle ar_ready=%b r_valid=%b want 1 0", ar_ready, r_valid);
        end
        checks++;
        if (r_obs.size() != r_exp.size()) begin
            errors++; $display("FAIL rd_count got %0d want %0d", r_obs.size(), r_exp.size());
        end
        foreach (r_exp[i])
            if (i < r_obs.size()) begin
                checks++;
                if (r_obs[i] !== r_exp[i]) begin
                    errors++; $display("FAIL rd_payload%0d got %h want %h", i, r_obs[i], r_exp[i]);
                end
            end
        r_obs.delete(); r_exp.delete();
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] id;
        rbeat_t prev, cur;
        logic hold;
        int got, len;
        id = IW'($urandom);
        aw_valid = 1; aw_id = id; aw_addr = {$urandom, $urandom};
        tick();
        aw_valid = 0; w_valid = 1; w_last = 1;
        tick();
        w_valid = 0; w_last = 0; b_ready = 0;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (b_valid !== 1'b1 || b_id !== id) begin
                errors++; $display("FAIL bp_bhold valid=%b id=%0d want 1 %0d", b_valid, b_id, id);
            end
            tick();
        end
        b_ready = 1;
        tick();
        b_ready = 0;
        checks++;
        if (b_obs.size() != 1 || b_obs[0] !== b_exp[0]) begin
            errors++; $display("FAIL bp_bcount got %0d want 1", b_obs.size());
        end
        b_obs.delete(); b_exp.delete();

        len = $urandom_range(2, 9);
        ar_valid = 1; ar_id = IW'($urandom); ar_len = 8'(len); ar_addr = {$urandom, $urandom};
        tick();
        ar_valid = 0;
        got = 0; hold = 0; prev = '0;
        for (int t = 0; t < 200 && got < len + 1; t++) begin
            r_ready = (t % 2 == 0);
            cur.id = r_id; cur.data = r_data; cur.resp = r_resp; cur.last = r_last;
            if (hold) begin
                checks++;
                if (r_valid !== 1'b1 || cur !== prev) begin
                    errors++; $display("FAIL bp_rstable got %b/%h want 1/%h", r_valid, cur, prev);
                end
            end
            hold = r_valid && !r_ready;
            prev = cur;
            if (r_valid && r_ready) got++;
            tick();
        end
        r_ready = 0;
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            errors++; $display("FAIL bp_rdone r_valid=%b ar_ready=%b want 0 1", r_valid, ar_ready);
        end
        checks++;
        if (r_obs.size() != len + 1 || r_exp.size() != len + 1) begin
            errors++; $display("FAIL bp_rcount got %0d want %0d", r_obs.size(), len + 1);
        end
        foreach (r_exp[i])
            if (i < r_obs.size()) begin
                checks++;
                if (r_obs[i] !== r_exp[i]) begin
                    errors++; $display("FAIL bp_rpayload%0d got %h want %h", i, r_obs[i], r_exp[i]);
                end
            end
        r_obs.delete(); r_exp.delete();
    endtask

    task automatic test_w_no_aw();
        w_valid = 1; w_last = 1; b_ready = 1;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (w_ready !== 1'b0 || b_valid !== 1'b0) begin
                errors++; $display("FAIL orphan_w w_ready=%b b_valid=%b want 0 0", w_ready, b_valid);
            end
            tick();
        end
        w_valid = 0; w_last = 0; b_ready = 0;
        checks++;
        if (b_obs.size() != 0) begin
            errors++; $display("FAIL orphan_b got %0d want 0", b_obs.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            aw_valid = ($urandom_range(0, 3) == 0);
            aw_id = IW'($urandom); aw_addr = {$urandom, $urandom}; aw_len = 8'($urandom);
            w_valid = 1'($urandom_range(0, 1)); w_last = ($urandom_range(0, 2) == 0);
            b_ready = 1'($urandom_range(0, 1));
            ar_valid = ($urandom_range(0, 3) == 0);
            ar_id = IW'($urandom); ar_addr = {$urandom, $urandom}; ar_len = 8'($urandom_range(0, 4));
            r_ready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (err_cnt !== 16'(m_cnt) || err_addr !== m_addr) begin
                errors++; $display("FAIL rnd_log cnt=%0d addr=%h want %0d %h", err_cnt, err_addr, m_cnt, m_addr);
            end
        end
        aw_valid = 0; ar_valid = 0; w_valid = 1; w_last = 1; b_ready = 1; r_ready = 1;
        for (int t = 0; t < 100 && (b_obs.size() < b_exp.size() || r_obs.size() < r_exp.size()); t++)
            tick();
        w_valid = 0; w_last = 0; b_ready = 0; r_ready = 0;
        checks++;
        if (b_obs.size() != b_exp.size() || r_obs.size() != r_exp.size()) begin
            errors++; $display("FAIL rnd_counts b=%0d/%0d r=%0d/%0d", b_obs.size(), b_exp.size(), r_obs.size(), r_exp.size());
        end
        foreach (b_exp[i])
            if (i < b_obs.size()) begin
                checks++;
                if (b_obs[i] !== b_exp[i]) begin
                    errors++; $display("FAIL rnd_b%0d got %h want %h", i, b_obs[i], b_exp[i]);
                end
            end
        foreach (r_exp[i])
            if (i < r_obs.size()) begin
                checks++;
                if (r_obs[i] !== r_exp[i]) begin
                    errors++; $display("FAIL rnd_r%0d got %h want %h", i, r_obs[i], r_exp[i]);
                end
            end
        r_obs.delete(); r_exp.delete(); b_obs.delete(); b_exp.delete();
    endtask

    task automatic test_saturate();
        logic [63:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        m_cnt = 32'hFFFE;
        tick();
        checks++;
        if (err_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL sat_preload cnt=%h want fffe", err_cnt);
        end
        aw_valid = 1; aw_addr = a; aw_id = IW'($urandom);
        ar_valid = 1; ar_addr = b; ar_id = IW'($urandom); ar_len = 8'($urandom_range(0, 3));
        tick();
        aw_valid = 0; ar_valid = 0;
        checks++;
        if (err_cnt !== 16'hFFFF || err_addr !== b) begin
            errors++; $display("FAIL sat_dual cnt=%h addr=%h want ffff %h", err_cnt, err_addr, b);
        end
        w_valid = 1; w_last = 1; b_ready = 1; r_ready = 1;
        for (int t = 0; t < 50 && (b_obs.size() < 1 || r_obs.size() < r_exp.size()); t++)
            tick();
        w_valid = 0; w_last = 0; b_ready = 0; r_ready = 0;
        checks++;
        if (b_obs.size() != 1 || r_obs.size() != r_exp.size() || b_obs[0] !== b_exp[0]) begin
            errors++; $display("FAIL sat_complete b=%0d r=%0d/%0d", b_obs.size(), r_obs.size(), r_exp.size());
        end
        ar_valid = 1; ar_len = 0; ar_addr = a;
        tick();
        ar_valid = 0;
        checks++;
        if (err_cnt !== 16'hFFFF || err_cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL sat_hold cnt=%h want ffff", err_cnt);
        end
        r_ready = 1;
        tick();
        r_ready = 0;
        r_obs.delete(); r_exp.delete(); b_obs.delete(); b_exp.delete();
    endtask

    task automatic test_reset_midburst();
        logic [95:0] v;
        aw_valid = 1; aw_id = IW'($urandom); aw_addr = {$urandom, $urandom};
        ar_valid = 1; ar_id = IW'($urandom); ar_len = 15; ar_addr = {$urandom, $urandom};
        r_ready = 1;
        tick();
        aw_valid = 0; ar_valid = 0; w_valid = 1; w_last = 0;
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        v = {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_id, r_id, err_addr, err_cnt};
        checks++;
        if (v !== {6'b110000, 90'd0}) begin
            errors++; $display("FAIL midrst_immediate got %h want %h", v, {6'b110000, 90'd0});
        end
        w_valid = 0; r_ready = 0;
        @(negedge clk);
        v = {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_id, r_id, err_addr, err_cnt};
        checks++;
        if (v !== {6'b110000, 90'd0}) begin
            errors++; $display("FAIL midrst_held got %h want %h", v, {6'b110000, 90'd0});
        end
        clear_model();
        rst_n = 1;
        tick();
        ar_valid = 1; ar_id = IW'($urandom); ar_len = 0; ar_addr = {$urandom, $urandom};
        tick();
        ar_valid = 0; r_ready = 1;
        checks++;
        if (r_valid !== 1'b1 || r_last !== 1'b1) begin
            errors++; $display("FAIL midrst_len0 valid=%b last=%b want 1 1", r_valid, r_last);
        end
        tick();
        tick();
        r_ready = 0;
        checks++;
        if (r_obs.size() != 1 || r_exp.size() != 1 || r_obs[0] !== r_exp[0] || ar_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_count got %0d want 1", r_obs.size());
        end
        checks++;
        if (err_cnt !== 16'(m_cnt) || err_addr !== m_addr) begin
            errors++; $display("FAIL midrst_log cnt=%0d addr=%h want %0d %h", err_cnt, err_addr, m_cnt, m_addr);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_w_no_aw();
        test_random();
        test_saturate();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
